// File: rtl/me_pkg.sv
// rtl/me_pkg.sv - shared types and defaults for the integer motion-estimation path
package me_pkg;

    localparam int SAD_WIDTH_DEF = 16;
    localparam int SEARCH_R_DEF  = 16;
    localparam int MV_WIDTH_DEF  = $clog2(SEARCH_R_DEF) + 1;

    // Signed motion-vector component at the default search range
    typedef logic signed [MV_WIDTH_DEF-1:0] mv_t;

    // Minimum-select controller states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_DONE   = 2'd2
    } me_sel_state_t;

endpackage

// File: rtl/mv_cost.sv
// rtl/mv_cost.sv - candidate cost (raw SAD, or SAD plus lambda-weighted MV length under SAD_MV_COST_EN)
module mv_cost
    import me_pkg::*;
#(
    parameter int SAD_WIDTH = SAD_WIDTH_DEF,
    parameter int MV_WIDTH  = MV_WIDTH_DEF,
    parameter int LAMBDA    = 4
) (
    input  logic [SAD_WIDTH-1:0]        sad_i,
    input  logic signed [MV_WIDTH-1:0]  mvx_i,
    input  logic signed [MV_WIDTH-1:0]  mvy_i,
    output logic [SAD_WIDTH:0]          cost_o
);

`ifdef SAD_MV_COST_EN
    // Magnitudes are taken as unsigned so that |-SEARCH_R| still fits in MV_WIDTH bits
    logic [MV_WIDTH-1:0] abs_x;
    logic [MV_WIDTH-1:0] abs_y;
    logic [MV_WIDTH:0]   abs_sum;
    logic [SAD_WIDTH:0]  penalty;

    assign abs_x   = mvx_i[MV_WIDTH-1] ? unsigned'(-mvx_i) : unsigned'(mvx_i);
    assign abs_y   = mvy_i[MV_WIDTH-1] ? unsigned'(-mvy_i) : unsigned'(mvy_i);
    assign abs_sum = {1'b0, abs_x} + {1'b0, abs_y};

    // LAMBDA*2*SEARCH_R stays below 2^SAD_WIDTH, so the one extra bit absorbs the sum
    assign penalty = (SAD_WIDTH+1)'(LAMBDA) * (SAD_WIDTH+1)'(abs_sum);
    assign cost_o  = {1'b0, sad_i} + penalty;
`else
    // Plain SAD compare: the vector inputs carry no weight in this build
    logic unused_mv;

    assign unused_mv = (^{mvx_i, mvy_i}) ^ (LAMBDA > 0);
    assign cost_o    = {1'b0, sad_i};
`endif

endmodule

// File: rtl/sad_min_select.sv
// rtl/sad_min_select.sv - minimum-SAD candidate tracker with valid/ready result; MV cost option SAD_MV_COST_EN
module sad_min_select
    import me_pkg::*;
#(
    parameter int SAD_WIDTH = SAD_WIDTH_DEF,
    parameter int SEARCH_R  = SEARCH_R_DEF,
    parameter int MV_WIDTH  = $clog2(SEARCH_R) + 1,
    parameter int LAMBDA    = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        abort,
    input  logic                        sad_valid,
    input  logic [SAD_WIDTH-1:0]        sad_in,
    output logic                        busy,
    output logic                        result_valid,
    input  logic                        result_ready,
    output logic [SAD_WIDTH-1:0]        best_sad,
    output logic signed [MV_WIDTH-1:0]  best_mvx,
    output logic signed [MV_WIDTH-1:0]  best_mvy
);

    localparam int N     = 4 * SEARCH_R * SEARCH_R;
    localparam int CNT_W = $clog2(N);

    localparam logic [CNT_W-1:0]           LAST_IDX = CNT_W'(N - 1);
    localparam logic signed [MV_WIDTH-1:0] MV_MIN   = MV_WIDTH'(-SEARCH_R);
    localparam logic signed [MV_WIDTH-1:0] MV_MAX   = MV_WIDTH'(SEARCH_R - 1);

    me_sel_state_t state_q, state_d;

    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic signed [MV_WIDTH-1:0] cur_mvx_q, cur_mvx_d;
    logic signed [MV_WIDTH-1:0] cur_mvy_q, cur_mvy_d;
    logic [SAD_WIDTH:0]         best_cost_q, best_cost_d;
    logic [SAD_WIDTH-1:0]       best_sad_q, best_sad_d;
    logic signed [MV_WIDTH-1:0] best_mvx_q, best_mvx_d;
    logic signed [MV_WIDTH-1:0] best_mvy_q, best_mvy_d;

    logic [SAD_WIDTH:0] cost;
    logic               start_search;
    logic               accept;

    mv_cost #(
        .SAD_WIDTH (SAD_WIDTH),
        .MV_WIDTH  (MV_WIDTH),
        .LAMBDA    (LAMBDA)
    ) u_mv_cost (
        .sad_i  (sad_in),
        .mvx_i  (cur_mvx_q),
        .mvy_i  (cur_mvy_q),
        .cost_o (cost)
    );

    // abort overrides every other input, so it also gates the datapath strobes
    assign start_search = (state_q == ST_IDLE) && start && !abort;
    assign accept       = (state_q == ST_SEARCH) && sad_valid && !abort;

    // Next-state logic: start in IDLE, last accepted sample ends SEARCH, handshake ends DONE
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:   if (start)                                state_d = ST_SEARCH;
                ST_SEARCH: if (sad_valid && (cnt_q == LAST_IDX))     state_d = ST_DONE;
                ST_DONE:   if (result_ready)                         state_d = ST_IDLE;
                default:                                             state_d = ST_IDLE;
            endcase
        end
    end

    // Raster walk over the window and strict-less-than tracking of the best candidate
    always_comb begin
        cnt_d       = cnt_q;
        cur_mvx_d   = cur_mvx_q;
        cur_mvy_d   = cur_mvy_q;
        best_cost_d = best_cost_q;
        best_sad_d  = best_sad_q;
        best_mvx_d  = best_mvx_q;
        best_mvy_d  = best_mvy_q;

        if (start_search) begin
            cnt_d       = '0;
            cur_mvx_d   = MV_MIN;
            cur_mvy_d   = MV_MIN;
            best_cost_d = '1;
        end else if (accept) begin
            // Strict compare keeps the earliest candidate on a tie
            if (cost < best_cost_q) begin
                best_cost_d = cost;
                best_sad_d  = sad_in;
                best_mvx_d  = cur_mvx_q;
                best_mvy_d  = cur_mvy_q;
            end
            cnt_d = cnt_q + CNT_W'(1);
            if (cur_mvx_q == MV_MAX) begin
                cur_mvx_d = MV_MIN;
                cur_mvy_d = cur_mvy_q + MV_WIDTH'(1);
            end else begin
                cur_mvx_d = cur_mvx_q + MV_WIDTH'(1);
            end
        end
    end

    // Controller state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Search datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            cur_mvx_q   <= '0;
            cur_mvy_q   <= '0;
            best_cost_q <= '1;
            best_sad_q  <= '0;
            best_mvx_q  <= '0;
            best_mvy_q  <= '0;
        end else begin
            cnt_q       <= cnt_d;
            cur_mvx_q   <= cur_mvx_d;
            cur_mvy_q   <= cur_mvy_d;
            best_cost_q <= best_cost_d;
            best_sad_q  <= best_sad_d;
            best_mvx_q  <= best_mvx_d;
            best_mvy_q  <= best_mvy_d;
        end
    end

    assign busy         = (state_q == ST_SEARCH);
    assign result_valid = (state_q == ST_DONE);
    assign best_sad     = best_sad_q;
    assign best_mvx     = best_mvx_q;
    assign best_mvy     = best_mvy_q;

endmodule

// File: tb/tb_sad_min_select.sv
// tb/tb_sad_min_select.sv - randomized self-checking bench for sad_min_select
module tb_sad_min_select;

    localparam int SW  = 16;
    localparam int R   = 2;
    localparam int MVW = $clog2(R) + 1;
    localparam int LAM = 4;
    localparam int N   = 4 * R * R;

    typedef int sad_arr_t [N];

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   start;
    logic                   abort;
    logic                   sad_valid;
    logic [SW-1:0]          sad_in;
    logic                   busy;
    logic                   result_valid;
    logic                   result_ready;
    logic [SW-1:0]          best_sad;
    logic signed [MVW-1:0]  best_mvx;
    logic signed [MVW-1:0]  best_mvy;

    int checks = 0;
    int fails  = 0;

    sad_min_select #(
        .SAD_WIDTH (SW),
        .SEARCH_R  (R),
        .LAMBDA    (LAM)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
        .sad_valid    (sad_valid),
        .sad_in       (sad_in),
        .busy         (busy),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .best_sad     (best_sad),
        .best_mvx     (best_mvx),
        .best_mvy     (best_mvy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    // Reference: walk candidates in raster order, keep the first strictly smaller cost
    task automatic model(input sad_arr_t s, output int bs, output int bx, output int by);
        int bc;
        bc = 32'h7fffffff;
        bs = 0; bx = 0; by = 0;
        for (int i = 0; i < N; i++) begin
            int mx, my, c;
            mx = -R + (i % (2 * R));
            my = -R + (i / (2 * R));
            c  = s[i];
`ifdef SAD_MV_COST_EN
            c = c + LAM * ((mx < 0 ? -mx : mx) + (my < 0 ? -my : my));
`endif
            if (c < bc) begin
                bc = c; bs = s[i]; bx = mx; by = my;
            end
        end
    endtask

    task automatic check_best(input string tag, input int bs, input int bx, input int by);
        check({tag, "_sad"}, 32'(best_sad), bs);
        check({tag, "_mvx"}, 32'($signed(best_mvx)), bx);
        check({tag, "_mvy"}, 32'($signed(best_mvy)), by);
    endtask

    task automatic random_sads(output sad_arr_t s);
        for (int i = 0; i < N; i++) s[i] = $urandom_range(0, 65280);
    endtask

    // One full search; a SAD of 0 rides along with start and must be discarded
    task automatic run_search(input string tag, input sad_arr_t s, input bit gaps, input bit early_ready,
                              output int bs, output int bx, output int by);
        model(s, bs, bx, by);
        start = 1'b1; sad_valid = 1'b1; sad_in = '0; result_ready = early_ready;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, "_busy_rise"}, 32'(busy), 1);
        for (int i = 0; i < N; i++) begin
            if (gaps) begin
                int g;
                g = $urandom_range(0, 2);
                repeat (g) begin
                    sad_valid = 1'b0;
                    sad_in = 16'($urandom);
                    start = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                end
            end
            if (i == N - 1) check({tag, "_rv_before_last"}, 32'(result_valid), 0);
            sad_valid = 1'b1;
            sad_in = 16'(s[i]);
            @(posedge clk); #1;
        end
        sad_valid = 1'b0; start = 1'b0;
        check({tag, "_rv_rise"}, 32'(result_valid), 1);
        check({tag, "_busy_fall"}, 32'(busy), 0);
        check_best(tag, bs, bx, by);
        if (early_ready) begin
            @(posedge clk); #1;
            check({tag, "_rv_one_cycle"}, 32'(result_valid), 0);
            result_ready = 1'b0;
        end
    endtask

    task automatic accept_result(input string tag);
        result_ready = 1'b1;
        @(posedge clk); #1;
        result_ready = 1'b0;
        check({tag, "_rv_drop"}, 32'(result_valid), 0);
    endtask

    initial begin
        sad_arr_t s;
        int bs, bx, by, bs1, bx1, by1;

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; sad_valid = 1'b0;
        sad_in = '0; result_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 32'(busy), 0);
        check("reset_rv", 32'(result_valid), 0);
        check_best("reset", 0, 0, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Minimum in the middle of the window
        for (int i = 0; i < N; i++) s[i] = 1000;
        s[9] = 37;
        run_search("min_mid", s, 1'b0, 1'b0, bs, bx, by);
        check_best("min_mid_spec", 37, -1, 0);
        accept_result("min_mid");

        // Tie between indices 3 and 12
        for (int i = 0; i < N; i++) s[i] = 200;
        s[3] = 5; s[12] = 5;
        run_search("tie", s, 1'b0, 1'b0, bs, bx, by);
        accept_result("tie");

        // Same random window with and without gaps/stray starts; ready held high early
        random_sads(s);
        run_search("rand_nogap", s, 1'b0, 1'b1, bs1, bx1, by1);
        run_search("rand_gap", s, 1'b1, 1'b1, bs, bx, by);
        check("gap_same_sad", bs, bs1);
        check("gap_same_mvx", bx, bx1);
        check("gap_same_mvy", by, by1);

        // Backpressure: result must hold for 20 cycles with ready low
        random_sads(s);
        run_search("bp", s, 1'b0, 1'b0, bs, bx, by);
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            check("bp_rv_hold", 32'(result_valid), 1);
            check_best("bp_hold", bs, bx, by);
        end
        accept_result("bp");
        check_best("bp_after", bs, bx, by);

        // Abort after 7 accepted SADs
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            sad_valid = 1'b1; sad_in = 16'($urandom_range(0, 65280));
            @(posedge clk); #1;
        end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_busy", 32'(busy), 0);
        check("abort_rv", 32'(result_valid), 0);
        for (int i = 0; i < 20; i++) begin
            sad_in = 16'($urandom_range(0, 65280));
            @(posedge clk); #1;
            check("abort_no_rv", 32'(result_valid), 0);
        end
        sad_valid = 1'b0;

        // Abort while the result is waiting
        random_sads(s);
        run_search("abort_done", s, 1'b0, 1'b0, bs, bx, by);
        abort = 1'b1; result_ready = 1'b0;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_done_rv", 32'(result_valid), 0);

        // Cost-weighting window: 100 at (0,0), 95 at (-2,-2)
        for (int i = 0; i < N; i++) s[i] = 500;
        s[10] = 100; s[0] = 95;
        run_search("cost", s, 1'b0, 1'b0, bs, bx, by);
        accept_result("cost");

        // Asynchronous reset in the middle of a search
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sad_valid = 1'b1; sad_in = 16'($urandom_range(0, 65280));
            @(posedge clk); #1;
        end
        #3 rst_n = 1'b0;
        #1;
        check("areset_busy", 32'(busy), 0);
        check("areset_rv", 32'(result_valid), 0);
        check_best("areset", 0, 0, 0);
        sad_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        random_sads(s);
        run_search("post_reset", s, 1'b1, 1'b0, bs, bx, by);
        accept_result("post_reset");

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
